// File: rtl/pmd901_spi_master.sv
// SPI master for the PMD901 motor driver: 16-bit speed words, SPI mode 0, MSB first, plus park/bend pins.
// Define PMD901_FAULT_ABORT_EN to let the fault input abort a frame in flight.
module pmd901_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int CSN_SETUP = 2,
  parameter int CSN_HOLD  = 2,
  parameter int CSN_IDLE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] speed_data,
  input  logic        speed_valid,
  output logic        speed_ready,
  input  logic        park_req,
  input  logic        bend_req,
  output logic        sclk,
  output logic        csn,
  output logic        mosi,
  output logic        park,
  output logic        bend,
  input  logic        fault,
  output logic        frame_done,
  output logic        frame_aborted
);

  localparam int CW = 16;
  localparam logic [4:0] LAST_HALF = 5'd30;  // 16 high + 15 low half-periods

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    half, half_n;
  logic [15:0]   shreg, shreg_n;
  logic          sclk_n, csn_n, mosi_n, park_n, bend_n, done_n;

  assign speed_ready = (state == IDLE) && park && !rst;

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    half_n  = half;
    shreg_n = shreg;
    sclk_n  = sclk;
    csn_n   = csn;
    mosi_n  = mosi;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        csn_n  = 1'b1;
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        if (speed_valid && speed_ready) begin
          state_n = SETUP;
          shreg_n = speed_data;
          mosi_n  = speed_data[15];
          csn_n   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == CW'(CSN_SETUP - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          half_n  = '0;
          sclk_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n  = '0;
          half_n = half + 1'b1;
          sclk_n = !sclk;
          // Data moves on the falling edge so it is stable around the next rise.
          if (sclk) begin
            shreg_n = {shreg[14:0], 1'b0};
            mosi_n  = shreg[14];
          end
          if (half == LAST_HALF) state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == CW'(CSN_HOLD - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
          csn_n   = 1'b1;
          mosi_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        // The IDLE cycle that accepts the next word is the last csn-high cycle.
        if (int'(cnt) + 2 >= CSN_IDLE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

`ifdef PMD901_FAULT_ABORT_EN
    if (fault && (state == SETUP || state == SHIFT || state == HOLD)) begin
      state_n = GAP;
      cnt_n   = '0;
      csn_n   = 1'b1;
      sclk_n  = 1'b0;
      mosi_n  = 1'b0;
      done_n  = 1'b0;
    end
`endif

    // Pins only move when csn is high in the following cycle.
    park_n = park;
    bend_n = bend;
    if (state_n == IDLE || state_n == GAP) begin
      park_n = park_req;
      bend_n = bend_req;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= '0;
      // NOTE: the shift register is reset too; it is small and makes an aborted word unobservable.
      shreg      <= '0;
      sclk       <= 1'b0;
      csn        <= 1'b1;
      mosi       <= 1'b0;
      park       <= 1'b0;
      bend       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      half       <= half_n;
      shreg      <= shreg_n;
      sclk       <= sclk_n;
      csn        <= csn_n;
      mosi       <= mosi_n;
      park       <= park_n;
      bend       <= bend_n;
      frame_done <= done_n;
    end
  end

`ifdef PMD901_FAULT_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) frame_aborted <= 1'b0;
    else     frame_aborted <= fault && (state == SETUP || state == SHIFT || state == HOLD);
  end
`else
  logic unused_fault;
  assign unused_fault  = fault;
  assign frame_aborted = 1'b0;
`endif

endmodule

// File: tb/tb_pmd901_spi_master.sv
// Self-checking bench for pmd901_spi_master: directed vector table, corner sequences and randomized words
// checked by a frame-level monitor. Honours PMD901_FAULT_ABORT_EN the same way as the design.
module tb_pmd901_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] speed_data = '0;
  logic        speed_valid = 1'b0;
  logic        speed_ready;
  logic        park_req = 1'b0;
  logic        bend_req = 1'b0;
  logic        sclk, csn, mosi, park, bend;
  logic        fault = 1'b0;
  logic        frame_done, frame_aborted;

  pmd901_spi_master dut (
    .clk(clk), .rst(rst),
    .speed_data(speed_data), .speed_valid(speed_valid), .speed_ready(speed_ready),
    .park_req(park_req), .bend_req(bend_req),
    .sclk(sclk), .csn(csn), .mosi(mosi), .park(park), .bend(bend),
    .fault(fault), .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  always #5 clk = ~clk;

  localparam int FRAME_LEN = 2 + 32 * 4 - 4 + 2;  // 128 cycles with csn low
  localparam int GAP_LEN   = 4;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the ordered list of words the bench has offered; each completed frame must carry
  // the oldest outstanding one, and a cut (reset/abort) frame discards it.
  logic [15:0] exp_q[$];

  // Request levels as the DUT saw them at the last rising edge.
  logic bend_req_q, park_req_q;
  always @(posedge clk) begin
    bend_req_q <= bend_req;
    park_req_q <= park_req;
  end

  // Frame monitor
  bit          mon_en = 0;
  logic        prev_csn = 1'b1, prev_sclk = 1'b0, prev_park = 1'b0, prev_bend = 1'b0;
  int          rises = 0, low_len = 0, high_len = 0, last_high = 0, last_len = 0;
  int          frames_ended = 0, done_cycles = 0, abort_cycles = 0, cut_frames = 0;
  logic [15:0] bits = '0, last_bits = '0;
  logic        last_bend = 1'b0, pin_moved = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (frame_done) begin
        done_cycles++;
        check("done_at_csn_rise", {31'b0, csn && !prev_csn}, 32'd1);
      end
      if (frame_aborted) abort_cycles++;
      if (!csn) begin
        if (prev_csn) begin
          last_high = high_len;
          low_len   = 0;
          rises     = 0;
          bits      = '0;
          pin_moved = 1'b0;
        end
        low_len++;
        if (sclk && !prev_sclk) begin
          bits = {bits[14:0], mosi};
          rises++;
        end
        if (park !== prev_park || bend !== prev_bend) pin_moved = 1'b1;
      end else begin
        if (!prev_csn) begin
          frames_ended++;
          high_len = 0;
          if (frame_done) begin
            if (exp_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
            else check("frame_bits", {16'b0, bits}, {16'b0, exp_q.pop_front()});
            check("frame_len", low_len, FRAME_LEN);
            check("frame_rises", rises, 16);
            check("pins_quiet_in_frame", {31'b0, pin_moved}, 32'd0);
            check("bend_at_gap", {31'b0, bend}, {31'b0, bend_req_q});
            check("park_at_gap", {31'b0, park}, {31'b0, park_req_q});
            last_bits = bits;
            last_len  = low_len;
            last_bend = bend;
          end else begin
            cut_frames++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
        end
        high_len++;
      end
      prev_csn  = csn;
      prev_sclk = sclk;
      prev_park = park;
      prev_bend = bend;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    bit ok = 0;
    speed_data  = w;
    speed_valid = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < 3000; i++) begin
      if (speed_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    step();
    speed_valid = 1'b0;
    speed_data  = 16'($urandom);  // must not disturb the frame in flight
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int target);
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (frames_ended >= target) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check("frame_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rise(input int n);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!csn && rises >= n) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check("sclk_rise_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        bend_mid;   // bend_req driven at the 5th sclk rise
    logic [15:0] exp_bits;   // bits the slave must sample, MSB first
    logic        exp_bend;   // bend in the first csn-high cycle
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fe, dc, n;
    int exp_cuts;
    bit bad;

    vecs[0] = '{16'hA5C3, 1'b0, 16'b1010_0101_1100_0011, 1'b0};
    vecs[1] = '{16'h0001, 1'b1, 16'b0000_0000_0000_0001, 1'b1};
    vecs[2] = '{16'h8000, 1'b1, 16'b1000_0000_0000_0000, 1'b1};
    vecs[3] = '{16'h3C5A, 1'b0, 16'b0011_1100_0101_1010, 1'b0};
    exp_cuts = 1;

    // Reset values
    repeat (3) @(posedge clk);
    step();
    check("rst_csn", {31'b0, csn}, 32'd1);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_park", {31'b0, park}, 32'd0);
    check("rst_bend", {31'b0, bend}, 32'd0);
    check("rst_ready", {31'b0, speed_ready}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_aborted", {31'b0, frame_aborted}, 32'd0);
    rst    = 1'b0;
    mon_en = 1;

    // Parked: a waiting word is neither accepted nor dropped
    speed_data  = 16'h1234;
    speed_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (speed_ready || !csn) bad = 1;
    end
    check("parked_holds_word", {31'b0, bad}, 32'd0);
    park_req = 1'b1;
    step();
    check("park_follows_req", {31'b0, park}, 32'd1);
    fe = frames_ended;
    send(16'h1234);
    wait_frames(fe + 1);
    check("parked_word_sent", {16'b0, last_bits}, 32'h1234);

    // Directed vector table, bend_req changed mid-SHIFT
    for (int v = 0; v < 4; v++) begin
      logic bend_before;
      fe = frames_ended;
      dc = done_cycles;
      send(vecs[v].word);
      wait_rise(5);
      bend_before = bend;
      bend_req = vecs[v].bend_mid;
      step();
      check("bend_held_mid_frame", {31'b0, bend}, {31'b0, bend_before});
      wait_frames(fe + 1);
      check("vec_bits", {16'b0, last_bits}, {16'b0, vecs[v].exp_bits});
      check("vec_len", last_len, FRAME_LEN);
      check("vec_bend_at_gap", {31'b0, last_bend}, {31'b0, vecs[v].exp_bend});
      check("vec_done_once", done_cycles - dc, 1);
    end

    // Back-to-back words
    bend_req = 1'b0;
    fe = frames_ended;
    send(16'hFFFF);
    send(16'h0001);
    wait_frames(fe + 2);
    check("b2b_csn_high_gap", last_high, GAP_LEN);
    check("b2b_second_bits", {16'b0, last_bits}, 32'h0001);

    // Reset at the 8th sclk rise
    dc = done_cycles;
    send(16'hBEEF);
    wait_rise(8);
    rst = 1'b1;
    step();
    check("midrst_csn", {31'b0, csn}, 32'd1);
    check("midrst_sclk", {31'b0, sclk}, 32'd0);
    check("midrst_mosi", {31'b0, mosi}, 32'd0);
    check("midrst_park", {31'b0, park}, 32'd0);
    check("midrst_done", {31'b0, frame_done}, 32'd0);
    rst = 1'b0;
    repeat (150) step();
    check("midrst_no_done", done_cycles - dc, 0);

    // Fault at the 5th sclk rise
    fe = frames_ended;
    dc = done_cycles;
    send(16'h5A5A);
    wait_rise(5);
    fault = 1'b1;
    step();
    fault = 1'b0;
`ifdef PMD901_FAULT_ABORT_EN
    exp_cuts++;
    check("abort_csn", {31'b0, csn}, 32'd1);
    check("abort_sclk", {31'b0, sclk}, 32'd0);
    check("abort_mosi", {31'b0, mosi}, 32'd0);
    check("abort_pulse", {31'b0, frame_aborted}, 32'd1);
    n = 1;
    while (!speed_ready && n < 20) begin
      step();
      n++;
    end
    check("abort_ready_delay", n, 4);
    check("abort_no_done", done_cycles - dc, 0);
    check("abort_cycles", abort_cycles, 1);
`else
    wait_frames(fe + 1);
    check("fault_ignored_bits", {16'b0, last_bits}, 32'h5A5A);
    check("fault_ignored_done", done_cycles - dc, 1);
    check("aborted_tied_low", abort_cycles, 0);
`endif

    // Randomized words, gaps and bend toggles against the queue model
    fe = frames_ended;
    for (int k = 0; k < 12; k++) begin
      int gap;
      bend_req = 1'($urandom);
      send(16'($urandom));
      gap = $urandom_range(0, 160);
      for (int c = 0; c < gap; c++) begin
        if ($urandom_range(0, 31) == 0) bend_req = ~bend_req;
        step();
      end
    end
    wait_frames(fe + 12);
    repeat (10) step();

    check("queue_drained", exp_q.size(), 0);
    check("cut_frames", cut_frames, exp_cuts);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
